// File: rtl/memory_axil_master_pkg.sv
// ---------------------------------------------------------------------------
// memory_axil_master_pkg
// Shared definitions for the load/store unit AXI4-Lite front-end:
//   - load/store type encoding (LS_TYPE_*) carried on i_Load_Store_Type
//   - AXI response codes
//   - small helpers classifying a type and detecting misalignment
// ---------------------------------------------------------------------------
package memory_axil_master_pkg;

    localparam int LS_SEL_WIDTH  = 3;
    localparam int LS_TYPE_WIDTH = LS_SEL_WIDTH + 1;

    localparam logic [LS_TYPE_WIDTH-1:0] LS_TYPE_NONE = 4'h0;
    localparam logic [LS_TYPE_WIDTH-1:0] LS_TYPE_LB   = 4'h1;
    localparam logic [LS_TYPE_WIDTH-1:0] LS_TYPE_LH   = 4'h2;
    localparam logic [LS_TYPE_WIDTH-1:0] LS_TYPE_LW   = 4'h3;
    localparam logic [LS_TYPE_WIDTH-1:0] LS_TYPE_LBU  = 4'h4;
    localparam logic [LS_TYPE_WIDTH-1:0] LS_TYPE_LHU  = 4'h5;
    localparam logic [LS_TYPE_WIDTH-1:0] LS_TYPE_SB   = 4'h6;
    localparam logic [LS_TYPE_WIDTH-1:0] LS_TYPE_SH   = 4'h7;
    localparam logic [LS_TYPE_WIDTH-1:0] LS_TYPE_SW   = 4'h8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic ls_is_load(input logic [LS_TYPE_WIDTH-1:0] t);
        return (t == LS_TYPE_LB) || (t == LS_TYPE_LH) || (t == LS_TYPE_LW) ||
               (t == LS_TYPE_LBU) || (t == LS_TYPE_LHU);
    endfunction

    function automatic logic ls_is_store(input logic [LS_TYPE_WIDTH-1:0] t);
        return (t == LS_TYPE_SB) || (t == LS_TYPE_SH) || (t == LS_TYPE_SW);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic ls_misaligned(input logic [LS_TYPE_WIDTH-1:0] t,
                                           input logic [1:0]               off);
        logic is_half;
        logic is_word;
        is_half = (t == LS_TYPE_LH) || (t == LS_TYPE_LHU) || (t == LS_TYPE_SH);
        is_word = (t == LS_TYPE_LW) || (t == LS_TYPE_SW);
        return (is_half && off[0]) || (is_word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/memory_lane_align.sv
// ---------------------------------------------------------------------------
// memory_lane_align
// Combinational byte-lane steering between a 32-bit CPU view and a 32-bit
// AXI data bus.
//   Store side: i_St_Type/i_St_Off/i_St_Data -> o_Wstrb/o_Wdata
//               (sub-word data is replicated across the bus, strobe selects)
//   Load side:  i_Ld_Type/i_Ld_Off/i_Rdata   -> o_Ld_Data
//               (lane shifted down, then sign- or zero-extended)
// ---------------------------------------------------------------------------
module memory_lane_align
    import memory_axil_master_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [LS_TYPE_WIDTH-1:0] i_St_Type,
    input  logic [1:0]               i_St_Off,
    input  logic [XLEN-1:0]          i_St_Data,
    output logic [3:0]               o_Wstrb,
    output logic [XLEN-1:0]          o_Wdata,
    input  logic [LS_TYPE_WIDTH-1:0] i_Ld_Type,
    input  logic [1:0]               i_Ld_Off,
    input  logic [XLEN-1:0]          i_Rdata,
    output logic [XLEN-1:0]          o_Ld_Data
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_Rdata >> {i_Ld_Off, 3'b000};

    always_comb begin
        o_Wstrb = 4'b0000;
        o_Wdata = i_St_Data;
        case (i_St_Type)
            LS_TYPE_SB: begin
                o_Wstrb = 4'b0001 << i_St_Off;
                o_Wdata = {4{i_St_Data[7:0]}};
            end
            LS_TYPE_SH: begin
                o_Wstrb = 4'b0011 << i_St_Off;
                o_Wdata = {2{i_St_Data[15:0]}};
            end
            LS_TYPE_SW: begin
                o_Wstrb = 4'b1111;
                o_Wdata = i_St_Data;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_Ld_Data = i_Rdata;
        case (i_Ld_Type)
            LS_TYPE_LB:  o_Ld_Data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LS_TYPE_LBU: o_Ld_Data = {24'h000000, w_shifted[7:0]};
            LS_TYPE_LH:  o_Ld_Data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LS_TYPE_LHU: o_Ld_Data = {16'h0000, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_axil_master.sv
// ---------------------------------------------------------------------------
// memory_axil_master
// CPU load/store front-end that turns one memory-stage request into a single
// AXI4-Lite read or write and reports completion back to the CPU.
// Ports:
//   i_Clock, i_Reset_N (sync, active-low)
//   CPU side : i_Request, i_Write_Enable, i_Load_Store_Type, i_Addr, i_Data,
//              o_Data, o_Ready, o_Data_Valid, o_Write_Done, o_Error
//   AXI AR/R : o_axil_araddr, o_axil_arvalid, i_axil_arready,
//              i_axil_rdata, i_axil_rresp, i_axil_rvalid, o_axil_rready
//   AXI AW/W : o_axil_awaddr, o_axil_awvalid, i_axil_awready,
//              o_axil_wdata, o_axil_wstrb, o_axil_wvalid, i_axil_wready
//   AXI B    : i_axil_bresp, i_axil_bvalid, o_axil_bready
// ---------------------------------------------------------------------------
module memory_axil_master
    import memory_axil_master_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset_N,
    input  logic                     i_Request,
    input  logic                     i_Write_Enable,
    input  logic [LS_TYPE_WIDTH-1:0] i_Load_Store_Type,
    input  logic [XLEN-1:0]          i_Addr,
    input  logic [XLEN-1:0]          i_Data,
    output logic [XLEN-1:0]          o_Data,
    output logic                     o_Ready,
    output logic                     o_Data_Valid,
    output logic                     o_Write_Done,
    output logic                     o_Error,
    output logic [ADDR_WIDTH-1:0]    o_axil_araddr,
    output logic                     o_axil_arvalid,
    input  logic                     i_axil_arready,
    input  logic [XLEN-1:0]          i_axil_rdata,
    input  logic [1:0]               i_axil_rresp,
    input  logic                     i_axil_rvalid,
    output logic                     o_axil_rready,
    output logic [ADDR_WIDTH-1:0]    o_axil_awaddr,
    output logic                     o_axil_awvalid,
    input  logic                     i_axil_awready,
    output logic [XLEN-1:0]          o_axil_wdata,
    output logic [3:0]               o_axil_wstrb,
    output logic                     o_axil_wvalid,
    input  logic                     i_axil_wready,
    input  logic [1:0]               i_axil_bresp,
    input  logic                     i_axil_bvalid,
    output logic                     o_axil_bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [LS_TYPE_WIDTH-1:0] r_type;
    logic [1:0]               r_off;
    logic [ADDR_WIDTH-1:0]    r_axaddr;
    logic [XLEN-1:0]          r_data;
    logic [XLEN-1:0]          r_wdata;
    logic [3:0]               r_wstrb;
    logic                     r_arvalid;
    logic                     r_rready;
    logic                     r_awvalid;
    logic                     r_wvalid;
    logic                     r_bready;
    logic                     r_aw_done;
    logic                     r_w_done;
    logic                     r_ready;
    logic                     r_data_valid;
    logic                     r_write_done;
    logic                     r_error;

    logic [3:0]               w_st_wstrb;
    logic [XLEN-1:0]          w_st_wdata;
    logic [XLEN-1:0]          w_ld_data;
    logic                     w_aw_done;
    logic                     w_w_done;
    logic                     w_misaligned;
    logic                     w_unused_bits;

    // Store steering works on the live request so the strobe/data are ready
    // to register on the accept edge; load formatting uses the latched type.
    memory_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .i_St_Type (i_Load_Store_Type),
        .i_St_Off  (i_Addr[1:0]),
        .i_St_Data (i_Data),
        .o_Wstrb   (w_st_wstrb),
        .o_Wdata   (w_st_wdata),
        .i_Ld_Type (r_type),
        .i_Ld_Off  (r_off),
        .i_Rdata   (i_axil_rdata),
        .o_Ld_Data (w_ld_data)
    );

    assign w_misaligned  = ls_misaligned(i_Load_Store_Type, i_Addr[1:0]);
    // A channel counts as done if it already finished or handshakes now.
    assign w_aw_done     = r_aw_done | (r_awvalid & i_axil_awready);
    assign w_w_done      = r_w_done  | (r_wvalid  & i_axil_wready);
    // Only resp[1] distinguishes error from success; upper address bits are
    // outside the AXI address space.
    assign w_unused_bits = ^{i_Addr[XLEN-1:ADDR_WIDTH], i_axil_rresp[0], i_axil_bresp[0]};

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_state      <= S_IDLE;
            r_type       <= LS_TYPE_NONE;
            r_off        <= 2'b00;
            r_axaddr     <= '0;
            r_data       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= 4'b0000;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_ready      <= 1'b1;
            r_data_valid <= 1'b0;
            r_write_done <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_Request) begin
                        r_type   <= i_Load_Store_Type;
                        r_off    <= i_Addr[1:0];
                        r_axaddr <= {i_Addr[ADDR_WIDTH-1:2], 2'b00};
                        if (ls_is_load(i_Load_Store_Type)) begin
                            r_ready <= 1'b0;
                            if (w_misaligned) begin
                                r_data       <= '0;
                                r_data_valid <= 1'b1;
                                r_error      <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_arvalid <= 1'b1;
                                r_state   <= S_RD_ADDR;
                            end
                        end else if (ls_is_store(i_Load_Store_Type) && i_Write_Enable) begin
                            r_ready <= 1'b0;
                            if (w_misaligned) begin
                                r_write_done <= 1'b1;
                                r_error      <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_wdata   <= w_st_wdata;
                                r_wstrb   <= w_st_wstrb;
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                                r_aw_done <= 1'b0;
                                r_w_done  <= 1'b0;
                                r_state   <= S_WR_REQ;
                            end
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (i_axil_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (i_axil_rvalid) begin
                        r_rready     <= 1'b0;
                        r_error      <= i_axil_rresp[1];
                        r_data       <= i_axil_rresp[1] ? '0 : w_ld_data;
                        r_data_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_WR_REQ: begin
                    if (r_awvalid && i_axil_awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && i_axil_wready) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (i_axil_bvalid) begin
                        r_bready     <= 1'b0;
                        r_error      <= i_axil_bresp[1];
                        r_write_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_data_valid <= 1'b0;
                    r_write_done <= 1'b0;
                    r_error      <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_Data         = r_data;
    assign o_Ready        = r_ready;
    assign o_Data_Valid   = r_data_valid;
    assign o_Write_Done   = r_write_done;
    assign o_Error        = r_error;
    assign o_axil_araddr  = r_axaddr;
    assign o_axil_arvalid = r_arvalid;
    assign o_axil_rready  = r_rready;
    assign o_axil_awaddr  = r_axaddr;
    assign o_axil_awvalid = r_awvalid;
    assign o_axil_wdata   = r_wdata;
    assign o_axil_wstrb   = r_wstrb;
    assign o_axil_wvalid  = r_wvalid;
    assign o_axil_bready  = r_bready;

endmodule

// File: tb/tb_memory_axil_master.sv
// ---------------------------------------------------------------------------
// tb_memory_axil_master
// Drives CPU requests into memory_axil_master, answers with a behavioural
// AXI4-Lite slave holding 16 words, and checks results against a byte-array
// reference memory.
// ---------------------------------------------------------------------------
module tb_memory_axil_master;
    import memory_axil_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  lst = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] din = 32'h0;

    logic [31:0] o_data;
    logic        o_ready, o_dv, o_wd, o_err;
    logic [15:0] araddr, awaddr;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    memory_axil_master #(.XLEN(32), .ADDR_WIDTH(16)) dut (
        .i_Clock(clk), .i_Reset_N(rst_n), .i_Request(req), .i_Write_Enable(we),
        .i_Load_Store_Type(lst), .i_Addr(addr), .i_Data(din),
        .o_Data(o_data), .o_Ready(o_ready), .o_Data_Valid(o_dv),
        .o_Write_Done(o_wd), .o_Error(o_err),
        .o_axil_araddr(araddr), .o_axil_arvalid(arvalid), .i_axil_arready(arready),
        .i_axil_rdata(rdata), .i_axil_rresp(rresp), .i_axil_rvalid(rvalid),
        .o_axil_rready(rready),
        .o_axil_awaddr(awaddr), .o_axil_awvalid(awvalid), .i_axil_awready(awready),
        .o_axil_wdata(wdata), .o_axil_wstrb(wstrb), .o_axil_wvalid(wvalid),
        .i_axil_wready(wready),
        .i_axil_bresp(bresp), .i_axil_bvalid(bvalid), .o_axil_bready(bready)
    );

    // ---------------- behavioural AXI4-Lite slave ----------------
    logic [31:0] smem [16];
    logic [31:0] init_word [16];
    logic        preload = 1'b0;
    int          ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
    logic [1:0]  rd_resp = 2'b00, wr_resp = 2'b00;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    logic        r_pend = 1'b0, b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] r_data_q = 32'h0, cap_wdata = 32'h0;
    logic [1:0]  r_resp_q = 2'b00, b_resp_q = 2'b00;
    logic [15:0] cap_awaddr = 16'h0;
    logic [3:0]  cap_wstrb = 4'h0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    int          dv_cnt = 0, wd_cnt = 0, vcyc = 0;

    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign rvalid  = r_pend && (r_cnt == 0);
    assign rdata   = r_data_q;
    assign rresp   = r_resp_q;
    assign awready = awvalid && !aw_got && (aw_cnt >= aw_dly);
    assign wready  = wvalid && !w_got && (w_cnt >= w_dly);
    assign bvalid  = b_pend && (b_cnt == 0);
    assign bresp   = b_resp_q;

    always @(posedge clk) begin
        if (preload)
            for (int i = 0; i < 16; i++) smem[i] <= init_word[i];
        if (!rst_n) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (rvalid && rready) r_pend <= 1'b0;
            if (arvalid && arready) begin
                ar_cnt   <= 0;
                r_pend   <= 1'b1;
                r_cnt    <= r_dly;
                r_data_q <= smem[araddr[5:2]];
                r_resp_q <= rd_resp;
                ar_hs    <= ar_hs + 1;
            end else if (arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (r_pend && r_cnt > 0) r_cnt <= r_cnt - 1;

            if (awvalid && awready) begin
                aw_cnt <= 0; aw_got <= 1'b1; cap_awaddr <= awaddr; aw_hs <= aw_hs + 1;
            end else if (awvalid && !aw_got) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                w_cnt <= 0; w_got <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb;
                w_hs <= w_hs + 1;
            end else if (wvalid && !w_got) begin
                w_cnt <= w_cnt + 1;
            end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !b_pend) begin
                b_pend <= 1'b1; b_cnt <= b_dly; b_resp_q <= wr_resp;
            end
            if (b_pend && b_cnt > 0) b_cnt <= b_cnt - 1;
            if (bvalid && bready) begin
                b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_hs <= b_hs + 1;
                if (!b_resp_q[1])
                    for (int i = 0; i < 4; i++)
                        if (cap_wstrb[i]) smem[cap_awaddr[5:2]][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (o_dv) dv_cnt <= dv_cnt + 1;
        if (o_wd) wd_cnt <= wd_cnt + 1;
        if (arvalid || awvalid || wvalid) vcyc <= vcyc + 1;
    end

    // ---------------- reference model: byte-addressed memory ----------------
    logic [7:0] ref_mem [64];

    function automatic int size_of(input logic [3:0] t);
        if (t == LS_TYPE_LB || t == LS_TYPE_LBU || t == LS_TYPE_SB) return 1;
        if (t == LS_TYPE_LH || t == LS_TYPE_LHU || t == LS_TYPE_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] t, input int a);
        logic [31:0] v;
        case (t)
            LS_TYPE_LB:  v = {{24{ref_mem[a][7]}}, ref_mem[a]};
            LS_TYPE_LBU: v = {24'h0, ref_mem[a]};
            LS_TYPE_LH:  v = {{16{ref_mem[a+1][7]}}, ref_mem[a+1], ref_mem[a]};
            LS_TYPE_LHU: v = {16'h0, ref_mem[a+1], ref_mem[a]};
            default:     v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [3:0] t, input int a, input logic [31:0] d);
        for (int k = 0; k < size_of(t); k++) ref_mem[a+k] = d[8*k +: 8];
    endtask

    task automatic load_mem(input logic [31:0] word0);
        for (int i = 0; i < 16; i++) begin
            init_word[i] = (i == 0) ? word0 : $urandom;
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = init_word[i][8*k +: 8];
        end
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
    endtask

    // One request; returns latency in cycles after the accept cycle.
    task automatic run_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] od, output logic oerr,
                          output logic old, output logic tmo);
        lst = t; addr = a; din = d; we = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!(o_dv || o_wd) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        tmo  = !(o_dv || o_wd);
        od   = o_data;
        oerr = o_err;
        old  = o_dv;
        $display("op type=%0h addr=%h din=%h lat=%0d load=%0b data=%h err=%0b",
                 t, a, d, lat, old, od, oerr);
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        total++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
            bad++; $display("FAIL reset_axi: got %b want 00000", {arvalid, rready, awvalid, wvalid, bready}); end
        total++; if ({o_dv, o_wd, o_err} !== 3'b0) begin
            bad++; $display("FAIL reset_pulses: got %b want 000", {o_dv, o_wd, o_err}); end
        total++; if (o_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", o_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte();
        int lat; logic [31:0] od; logic oerr, old, tmo;
        load_mem(32'h80FF_FF00);
        run_op(LS_TYPE_LB, 32'h0003, 32'h0, lat, od, oerr, old, tmo);
        total++; if (tmo) begin bad++; $display("FAIL lb_timeout: got none want pulse"); end
        total++; if (od !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data: got %h want ffffff80", od); end
        total++; if (lat !== 3) begin bad++; $display("FAIL lb_latency: got %0d want 3", lat); end
        total++; if ({old, oerr} !== 2'b10) begin bad++; $display("FAIL lb_flags: got %b want 10", {old, oerr}); end
    endtask

    task automatic test_store_half();
        int lat; logic [31:0] od; logic oerr, old, tmo;
        run_op(LS_TYPE_SH, 32'h0006, 32'h1234_ABCD, lat, od, oerr, old, tmo);
        model_store(LS_TYPE_SH, 6, 32'h1234_ABCD);
        total++; if (tmo) begin bad++; $display("FAIL sh_timeout: got none want pulse"); end
        total++; if (cap_awaddr !== 16'h0004) begin bad++; $display("FAIL sh_awaddr: got %h want 0004", cap_awaddr); end
        total++; if (cap_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb: got %b want 1100", cap_wstrb); end
        total++; if (cap_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata: got %h want abcdabcd", cap_wdata); end
        total++; if (lat !== 3) begin bad++; $display("FAIL sh_latency: got %0d want 3", lat); end
        total++; if ({old, oerr} !== 2'b00) begin bad++; $display("FAIL sh_flags: got %b want 00", {old, oerr}); end
        run_op(LS_TYPE_LW, 32'h0004, 32'h0, lat, od, oerr, old, tmo);
        total++; if (od !== model_load(LS_TYPE_LW, 4)) begin
            bad++; $display("FAIL sh_readback: got %h want %h", od, model_load(LS_TYPE_LW, 4)); end
    endtask

    task automatic test_split_write();
        int a0, w0, b0, d0, n;
        logic [31:0] d;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs; d0 = wd_cnt;
        aw_dly = 4; w_dly = 0;
        d = $urandom;
        lst = LS_TYPE_SW; addr = 32'h0008; din = d; we = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        total++; if ({awvalid, wvalid} !== 2'b11) begin bad++; $display("FAIL split_c1: got %b want 11", {awvalid, wvalid}); end
        @(posedge clk); #1;
        total++; if ({awvalid, wvalid} !== 2'b10) begin bad++; $display("FAIL split_c2: got %b want 10", {awvalid, wvalid}); end
        n = 0;
        while (!o_wd && n < 50) begin @(posedge clk); #1; n++; end
        total++; if (!o_wd) begin bad++; $display("FAIL split_timeout: got none want pulse"); end
        repeat (4) @(posedge clk);
        #1;
        model_store(LS_TYPE_SW, 8, d);
        total++; if ((aw_hs - a0) !== 1 || (w_hs - w0) !== 1 || (b_hs - b0) !== 1) begin
            bad++; $display("FAIL split_handshakes: got aw=%0d w=%0d b=%0d want 1 1 1", aw_hs - a0, w_hs - w0, b_hs - b0); end
        total++; if ((wd_cnt - d0) !== 1) begin bad++; $display("FAIL split_done_pulses: got %0d want 1", wd_cnt - d0); end
        aw_dly = 0;
    endtask

    task automatic test_misaligned();
        int lat, v0; logic [31:0] od; logic oerr, old, tmo;
        v0 = vcyc;
        run_op(LS_TYPE_LW, 32'h0002, 32'h0, lat, od, oerr, old, tmo);
        total++; if (lat !== 1) begin bad++; $display("FAIL mis_lw_latency: got %0d want 1", lat); end
        total++; if ({old, oerr, od} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL mis_lw_result: got %b %b %h want 1 1 0", old, oerr, od); end
        run_op(LS_TYPE_SH, 32'h0001, 32'h5555, lat, od, oerr, old, tmo);
        total++; if ({lat == 1, old, oerr} !== 3'b101) begin
            bad++; $display("FAIL mis_sh_result: got lat=%0d load=%b err=%b want 1 0 1", lat, old, oerr); end
        total++; if (vcyc !== v0) begin bad++; $display("FAIL mis_no_axi: got %0d want %0d", vcyc, v0); end
    endtask

    task automatic test_error_resp();
        int lat; logic [31:0] od; logic oerr, old, tmo;
        rd_resp = AXI_RESP_SLVERR;
        run_op(LS_TYPE_LHU, 32'h0004, 32'h0, lat, od, oerr, old, tmo);
        rd_resp = AXI_RESP_OKAY;
        total++; if ({old, oerr, od} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL err_lhu: got %b %b %h want 1 1 0", old, oerr, od); end
        wr_resp = AXI_RESP_DECERR;
        run_op(LS_TYPE_SW, 32'h000C, 32'hDEAD_BEEF, lat, od, oerr, old, tmo);
        wr_resp = AXI_RESP_OKAY;
        total++; if ({old, oerr} !== 2'b01) begin bad++; $display("FAIL err_sw: got %b want 01", {old, oerr}); end
        run_op(LS_TYPE_LW, 32'h000C, 32'h0, lat, od, oerr, old, tmo);
        total++; if (od !== model_load(LS_TYPE_LW, 12)) begin
            bad++; $display("FAIL err_sw_readback: got %h want %h", od, model_load(LS_TYPE_LW, 12)); end
    endtask

    task automatic test_reset_mid();
        int n;
        r_dly = 50;
        lst = LS_TYPE_LW; addr = 32'h0; we = 1'b0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (!rready && n < 10) begin @(posedge clk); #1; n++; end
        total++; if (rready !== 1'b1) begin bad++; $display("FAIL rst_mid_reach: got %b want 1", rready); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if ({arvalid, rready, awvalid, wvalid, bready, o_dv} !== 6'b0) begin
            bad++; $display("FAIL rst_mid_axi: got %b want 000000", {arvalid, rready, awvalid, wvalid, bready, o_dv}); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", o_ready); end
        rst_n = 1'b1;
        r_dly = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_ignored();
        int v0, d0, w0;
        v0 = vcyc; d0 = dv_cnt; w0 = wd_cnt;
        lst = LS_TYPE_SB; addr = 32'h0; din = 32'h77; we = 1'b0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL ign_we0_ready: got %b want 1", o_ready); end
        repeat (4) @(posedge clk);
        #1;
        lst = 4'hF; we = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL ign_type_ready: got %b want 1", o_ready); end
        repeat (4) @(posedge clk);
        #1;
        total++; if ({vcyc - v0, dv_cnt - d0, wd_cnt - w0} !== {32'd0, 32'd0, 32'd0}) begin
            bad++; $display("FAIL ign_activity: got valids=%0d dv=%0d wd=%0d want 0 0 0", vcyc - v0, dv_cnt - d0, wd_cnt - w0); end
    endtask

    task automatic test_random();
        logic [3:0] types [8] = '{LS_TYPE_LB, LS_TYPE_LH, LS_TYPE_LW, LS_TYPE_LBU,
                                  LS_TYPE_LHU, LS_TYPE_SB, LS_TYPE_SH, LS_TYPE_SW};
        logic [31:0] last_load = 32'h0;
        logic        have_load = 1'b0;
        for (int it = 0; it < 60; it++) begin
            logic [3:0]  t;
            int          a, sz, lat, exp_lat;
            logic [31:0] d, od, exp_d;
            logic        oerr, old, tmo, mis, rerr, is_ld, exp_err, zero_wait;
            t  = types[$urandom_range(0, 7)];
            sz = size_of(t);
            a  = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) a = a & ~(sz - 1);
            d  = $urandom;
            ar_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3); r_dly  = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0; end
            zero_wait = (ar_dly + aw_dly + w_dly + r_dly + b_dly) == 0;
            rerr = ($urandom_range(0, 5) == 0);
            rd_resp = rerr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            wr_resp = rerr ? AXI_RESP_DECERR : AXI_RESP_OKAY;
            is_ld = (t == LS_TYPE_LB || t == LS_TYPE_LH || t == LS_TYPE_LW ||
                     t == LS_TYPE_LBU || t == LS_TYPE_LHU);
            mis = (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
            exp_err = mis || rerr;
            exp_d = (is_ld && !exp_err) ? model_load(t, a) : 32'h0;
            exp_lat = mis ? 1 : 3;
            run_op(t, a, d, lat, od, oerr, old, tmo);
            total++; if (tmo) begin bad++; $display("FAIL rnd%0d_timeout: got none want pulse", it); end
            total++; if ({old, oerr} !== {is_ld, exp_err}) begin
                bad++; $display("FAIL rnd%0d_flags: got %b want %b", it, {old, oerr}, {is_ld, exp_err}); end
            if (is_ld) begin
                total++; if (od !== exp_d) begin bad++; $display("FAIL rnd%0d_data: got %h want %h", it, od, exp_d); end
                last_load = exp_d;
                have_load = 1'b1;
            end else if (have_load) begin
                total++; if (od !== last_load) begin bad++; $display("FAIL rnd%0d_hold: got %h want %h", it, od, last_load); end
            end
            if (zero_wait || mis) begin
                total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, exp_lat); end
            end
            if (!is_ld && !exp_err) model_store(t, a, d);
        end
        rd_resp = AXI_RESP_OKAY; wr_resp = AXI_RESP_OKAY;
        ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0;
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_split_write();
        test_misaligned();
        test_error_resp();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
